// File: rtl/rtc_a_vga_escritor_pkg.sv
// Shared types and constants for the RTC-to-VGA field writer.
package rtc_a_vga_escritor_pkg;

    localparam int unsigned AnchoByte = 8;

    localparam int unsigned PosSeg    = 0;
    localparam int unsigned PosMin    = 1;
    localparam int unsigned PosHora   = 2;
    localparam int unsigned PosDia    = 3;
    localparam int unsigned PosMes    = 4;
    localparam int unsigned PosAnio   = 5;
    localparam int unsigned PosCrSeg  = 6;
    localparam int unsigned PosCrMin  = 7;
    localparam int unsigned PosCrHora = 8;

    typedef enum logic [1:0] {
        StIdle,
        StEsperaV,
        StEnvia,
        StPausa
    } estado_t;

endpackage

// File: rtl/rtc_a_vga_escritor_if.sv
// Snapshot input and display strobe bundle between RTC controller, writer and VGA top.
interface rtc_a_vga_escritor_if #(
    parameter int unsigned N_CAMPOS = 9
);
    logic                  actualizar;
    logic [N_CAMPOS*8-1:0] datos_in;
    logic                  V_ON;
    logic [7:0]            DIR_DATO;
    logic [3:0]            POSICION;
    logic                  RD;
    logic                  ocupado;
    logic                  bcd_err;

    modport master (
        output actualizar, datos_in, V_ON,
        input  DIR_DATO, POSICION, RD, ocupado, bcd_err
    );

    modport slave (
        input  actualizar, datos_in, V_ON,
        output DIR_DATO, POSICION, RD, ocupado, bcd_err
    );
endinterface

// File: rtl/rtc_a_vga_escritor_bcd_sanear.sv
// Combinational BCD byte check: passes valid bytes, zeroes bytes with a nibble above 9.
module rtc_a_vga_escritor_bcd_sanear
    import rtc_a_vga_escritor_pkg::*;
(
    input  logic [AnchoByte-1:0] i_byte,
    output logic [AnchoByte-1:0] o_byte,
    output logic                 o_err
);
    always_comb begin
        o_err  = (i_byte[7:4] > 4'd9) || (i_byte[3:0] > 4'd9);
        o_byte = o_err ? '0 : i_byte;
    end
endmodule

// File: rtl/rtc_a_vga_escritor.sv
// Streams a captured BCD snapshot to the VGA character path, one field per RD strobe,
// starting only in vertical blanking.
module rtc_a_vga_escritor
    import rtc_a_vga_escritor_pkg::*;
#(
    parameter int unsigned N_CAMPOS = 9,
    parameter int unsigned ESPACIO  = 2
) (
    input logic                 reloj,
    input logic                 resetM,
    rtc_a_vga_escritor_if.slave bus
);
    localparam int unsigned AnchoDatos  = N_CAMPOS * AnchoByte;
    localparam logic [3:0]  UltimoIdx   = 4'(N_CAMPOS - 1);
    localparam logic [3:0]  UltimaPausa = 4'(ESPACIO - 1);

    estado_t               r_estado, w_estado_d;
    logic [AnchoDatos-1:0] r_actual, w_actual_d;
    logic [AnchoDatos-1:0] r_siguiente, w_siguiente_d;
    logic                  r_pendiente, w_pendiente_d;
    logic [3:0]            r_idx, w_idx_d;
    logic [3:0]            r_cnt, w_cnt_d;
    logic [7:0]            r_dir_dato, w_dir_dato_d;
    logic [3:0]            r_posicion, w_posicion_d;
    logic                  r_rd, w_rd_d;
    logic                  r_ocupado, w_ocupado_d;
    logic                  r_bcd_err, w_bcd_err_d;

    logic [AnchoByte-1:0]  w_byte_sel;
    logic [AnchoByte-1:0]  w_byte_ok;
    logic                  w_byte_err;

    assign w_byte_sel = r_actual[r_idx*AnchoByte +: AnchoByte];

    rtc_a_vga_escritor_bcd_sanear u_sanear (
        .i_byte (w_byte_sel),
        .o_byte (w_byte_ok),
        .o_err  (w_byte_err)
    );

    always_comb begin
        w_estado_d    = r_estado;
        w_actual_d    = r_actual;
        w_siguiente_d = r_siguiente;
        w_pendiente_d = r_pendiente;
        w_idx_d       = r_idx;
        w_cnt_d       = r_cnt;
        w_dir_dato_d  = r_dir_dato;
        w_posicion_d  = r_posicion;
        w_rd_d        = 1'b0;
        w_bcd_err_d   = r_bcd_err;
        // Stays high through the strobe cycle of the last field, drops the clock after.
        w_ocupado_d   = (r_estado != StIdle) || bus.actualizar;

        if (bus.actualizar && (r_estado != StIdle)) begin
            w_siguiente_d = bus.datos_in;
            w_pendiente_d = 1'b1;
        end

        unique case (r_estado)
            StIdle: begin
                if (bus.actualizar) begin
                    w_actual_d = bus.datos_in;
                    w_estado_d = StEsperaV;
                end
            end
            StEsperaV: begin
                if (!bus.V_ON) begin
                    w_idx_d    = '0;
                    w_estado_d = StEnvia;
                end
            end
            StEnvia: begin
                w_rd_d       = 1'b1;
                w_posicion_d = r_idx;
                w_dir_dato_d = w_byte_ok;
                w_bcd_err_d  = r_bcd_err | w_byte_err;
                if (r_idx != UltimoIdx) begin
                    w_cnt_d    = '0;
                    w_estado_d = StPausa;
                end else if (r_pendiente || bus.actualizar) begin
                    // A pulse landing on the last field is the newest snapshot; send it next.
                    w_actual_d    = bus.actualizar ? bus.datos_in : r_siguiente;
                    w_pendiente_d = 1'b0;
                    w_estado_d    = StEsperaV;
                end else begin
                    w_estado_d = StIdle;
                end
            end
            StPausa: begin
                if (r_cnt == UltimaPausa) begin
                    w_idx_d    = r_idx + 4'd1;
                    w_estado_d = StEnvia;
                end else begin
                    w_cnt_d = r_cnt + 4'd1;
                end
            end
            default: w_estado_d = StIdle;
        endcase
    end

    always_ff @(posedge reloj or negedge resetM) begin
        if (!resetM) begin
            r_estado    <= StIdle;
            r_actual    <= '0;
            r_siguiente <= '0;
            r_pendiente <= 1'b0;
            r_idx       <= '0;
            r_cnt       <= '0;
            r_dir_dato  <= '0;
            r_posicion  <= '0;
            r_rd        <= 1'b0;
            r_ocupado   <= 1'b0;
            r_bcd_err   <= 1'b0;
        end else begin
            r_estado    <= w_estado_d;
            r_actual    <= w_actual_d;
            r_siguiente <= w_siguiente_d;
            r_pendiente <= w_pendiente_d;
            r_idx       <= w_idx_d;
            r_cnt       <= w_cnt_d;
            r_dir_dato  <= w_dir_dato_d;
            r_posicion  <= w_posicion_d;
            r_rd        <= w_rd_d;
            r_ocupado   <= w_ocupado_d;
            r_bcd_err   <= w_bcd_err_d;
        end
    end

    assign bus.DIR_DATO = r_dir_dato;
    assign bus.POSICION = r_posicion;
    assign bus.RD       = r_rd;
    assign bus.ocupado  = r_ocupado;
    assign bus.bcd_err  = r_bcd_err;
endmodule

// File: tb/tb_rtc_a_vga_escritor.sv
// Scoreboard bench for rtc_a_vga_escritor: expected (POSICION, DIR_DATO) pairs are queued
// when a snapshot is driven and popped on every RD strobe.
module tb_rtc_a_vga_escritor;

    logic reloj;
    logic resetM;

    rtc_a_vga_escritor_if #(.N_CAMPOS(9)) bus ();

    rtc_a_vga_escritor #(
        .N_CAMPOS (9),
        .ESPACIO  (2)
    ) dut (
        .reloj  (reloj),
        .resetM (resetM),
        .bus    (bus)
    );

    initial reloj = 1'b0;
    always #5 reloj = ~reloj;

    int unsigned n_total = 0;
    int unsigned n_bad   = 0;
    int unsigned cyc     = 0;
    int unsigned pulse_cyc;
    int unsigned fin_cyc;
    int unsigned vdrop_cyc;

    logic [11:0]  sb_q[$];
    int unsigned  strobe_cycs[$];

    always @(posedge reloj) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h exp=%0h (cyc %0d)", tag, got, exp, cyc);
        end
    endtask

    // Expected stream for a snapshot; bytes with a nibble above 9 must arrive as 00.
    task automatic encolar(input logic [71:0] d, input int n);
        logic [7:0] b;
        for (int k = 0; k < n; k++) begin
            b = d[k*8 +: 8];
            if (b[7:4] > 4'd9 || b[3:0] > 4'd9) b = 8'h00;
            sb_q.push_back({4'(k), b});
        end
    endtask

    always @(negedge reloj) begin
        if (resetM && bus.RD) begin
            strobe_cycs.push_back(cyc);
            if (sb_q.size() == 0) begin
                check_eq("rd_inesperado", {31'd0, bus.RD}, 32'd0);
            end else begin
                logic [11:0] e;
                e = sb_q.pop_front();
                check_eq("posicion", {28'd0, bus.POSICION}, {28'd0, e[11:8]});
                check_eq("dir_dato", {24'd0, bus.DIR_DATO}, {24'd0, e[7:0]});
            end
        end
    end

    task automatic pulso(input logic [71:0] d);
        @(negedge reloj);
        bus.actualizar = 1'b1;
        bus.datos_in   = d;
        pulse_cyc      = cyc;
        @(negedge reloj);
        bus.actualizar = 1'b0;
    endtask

    task automatic esperar_fin(input int max);
        int i;
        for (i = 0; i < max; i++) begin
            @(negedge reloj);
            if (!bus.ocupado) break;
        end
        fin_cyc = cyc;
        if (i == max) check_eq("timeout_ocupado", {31'd0, bus.ocupado}, 32'd0);
    endtask

    task automatic esperar_strobes(input int n, input int max);
        int i;
        for (i = 0; i < max; i++) begin
            @(negedge reloj);
            if (strobe_cycs.size() >= n) break;
        end
        if (i == max) check_eq("timeout_strobes", strobe_cycs.size(), n);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got=running exp=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        resetM         = 1'b0;
        bus.actualizar = 1'b0;
        bus.datos_in   = '0;
        bus.V_ON       = 1'b0;
        repeat (3) @(negedge reloj);
        check_eq("rst_rd",       {31'd0, bus.RD},       32'd0);
        check_eq("rst_posicion", {28'd0, bus.POSICION}, 32'd0);
        check_eq("rst_dir_dato", {24'd0, bus.DIR_DATO}, 32'd0);
        check_eq("rst_ocupado",  {31'd0, bus.ocupado},  32'd0);
        check_eq("rst_bcd_err",  {31'd0, bus.bcd_err},  32'd0);
        resetM = 1'b1;
        repeat (2) @(negedge reloj);

        // Basic stream with V_ON already low.
        strobe_cycs.delete();
        encolar(72'h12_34_56_24_07_15_23_59_45, 9);
        pulso(72'h12_34_56_24_07_15_23_59_45);
        check_eq("ocupado_captura", {31'd0, bus.ocupado}, 32'd1);
        esperar_fin(200);
        check_eq("basic_n_strobes", strobe_cycs.size(), 32'd9);
        if (strobe_cycs.size() == 9) begin
            check_eq("basic_latencia", strobe_cycs[0] - pulse_cyc, 32'd3);
            for (int i = 1; i < 9; i++)
                check_eq("basic_espaciado", strobe_cycs[i] - strobe_cycs[i-1], 32'd3);
            check_eq("basic_ocupado_cae", fin_cyc, strobe_cycs[8] + 1);
        end
        check_eq("basic_rd_tras", {31'd0, bus.RD}, 32'd0);
        check_eq("basic_dato_retenido", {24'd0, bus.DIR_DATO}, 32'h12);
        check_eq("basic_pos_retenida", {28'd0, bus.POSICION}, 32'd8);

        // Blanking wait, with V_ON rising mid-stream.
        strobe_cycs.delete();
        bus.V_ON = 1'b1;
        encolar(72'h09_08_07_06_05_04_03_02_01, 9);
        pulso(72'h09_08_07_06_05_04_03_02_01);
        repeat (100) @(negedge reloj);
        check_eq("blank_sin_rd", strobe_cycs.size(), 32'd0);
        bus.V_ON  = 1'b0;
        vdrop_cyc = cyc;
        esperar_strobes(1, 20);
        if (strobe_cycs.size() >= 1)
            check_eq("blank_latencia", strobe_cycs[0] - vdrop_cyc, 32'd2);
        repeat (6) @(negedge reloj);
        bus.V_ON = 1'b1;
        esperar_fin(200);
        bus.V_ON = 1'b0;
        check_eq("blank_n_strobes", strobe_cycs.size(), 32'd9);

        // Mid-stream updates: the 0x11 snapshot is superseded by 0x22.
        strobe_cycs.delete();
        encolar(72'h98_76_54_31_12_01_20_30_33, 9);
        pulso(72'h98_76_54_31_12_01_20_30_33);
        esperar_strobes(3, 40);
        pulso(72'h11_11_11_11_11_11_11_11_11);
        esperar_strobes(5, 40);
        encolar(72'h88_77_66_55_44_33_19_09_22, 9);
        pulso(72'h88_77_66_55_44_33_19_09_22);
        esperar_fin(300);
        check_eq("mid_n_strobes", strobe_cycs.size(), 32'd18);
        check_eq("mid_sb_vacio", sb_q.size(), 32'd0);
        check_eq("bcd_err_previo", {31'd0, bus.bcd_err}, 32'd0);

        // Invalid BCD in both nibble positions.
        strobe_cycs.delete();
        encolar(72'h21_A5_19_18_17_16_3A_14_13, 9);
        pulso(72'h21_A5_19_18_17_16_3A_14_13);
        esperar_fin(200);
        check_eq("bcd_err_alto", {31'd0, bus.bcd_err}, 32'd1);
        encolar(72'h01_02_03_04_05_06_07_08_09, 9);
        pulso(72'h01_02_03_04_05_06_07_08_09);
        esperar_fin(200);
        check_eq("bcd_err_pegajoso", {31'd0, bus.bcd_err}, 32'd1);
        check_eq("bcd_n_strobes", strobe_cycs.size(), 32'd18);

        // Asynchronous reset during the fourth strobe.
        strobe_cycs.delete();
        encolar(72'h99_88_77_66_55_44_33_22_11, 4);
        pulso(72'h99_88_77_66_55_44_33_22_11);
        for (int i = 0; i < 40 && cyc != pulse_cyc + 12; i++) @(negedge reloj);
        #1 resetM = 1'b0;
        #1;
        check_eq("rstmid_rd",       {31'd0, bus.RD},       32'd0);
        check_eq("rstmid_posicion", {28'd0, bus.POSICION}, 32'd0);
        check_eq("rstmid_dir_dato", {24'd0, bus.DIR_DATO}, 32'd0);
        check_eq("rstmid_ocupado",  {31'd0, bus.ocupado},  32'd0);
        check_eq("rstmid_bcd_err",  {31'd0, bus.bcd_err},  32'd0);
        check_eq("rstmid_n_strobes", strobe_cycs.size(), 32'd4);
        repeat (2) @(negedge reloj);
        resetM = 1'b1;
        repeat (40) @(negedge reloj);
        check_eq("rstmid_silencio", strobe_cycs.size(), 32'd4);
        check_eq("rstmid_ocupado_tras", {31'd0, bus.ocupado}, 32'd0);
        encolar(72'h59_58_57_56_55_54_53_52_51, 9);
        pulso(72'h59_58_57_56_55_54_53_52_51);
        esperar_fin(200);
        check_eq("rstmid_reanuda", strobe_cycs.size(), 32'd13);
        check_eq("sb_final_vacio", sb_q.size(), 32'd0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
